// File: rtl/writeback_bram_q_k_v_if.sv
// Bundle of the command, input stream and BRAM port-A signals of the
// Q/K/V write-back block. The slave side is the write-back block itself.
interface writeback_bram_q_k_v_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 16
);
    logic                  start_write;
    logic                  reset_addr_counter;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  write_done;
    logic                  region_done;
    logic                  busy;

    modport master (
        output start_write, reset_addr_counter, in_valid, in_data,
        input  in_ready, ena, wea, addra, dina, write_done, region_done, busy
    );

    modport slave (
        input  start_write, reset_addr_counter, in_valid, in_data,
        output in_ready, ena, wea, addra, dina, write_done, region_done, busy
    );
endinterface

// File: rtl/writeback_bram_q_k_v.sv
// Q/K/V result write-back: takes result words from the compute array over a
// valid/ready stream and writes them, one tile per start_write, to
// consecutive BRAM port-A addresses of the activation region.
//
// state   | meaning
// IDLE    | waiting for start_write; reset_addr_counter may rewind the pointer
// WRITE   | accepting beats, each one registered onto port A one cycle later
// DONE    | last write on port A together with write_done (one cycle)
module writeback_bram_q_k_v #(
    parameter int NUM_WRITES_PER_TILE = 32,
    parameter int ADDR_WIDTH          = 16,
    parameter int WRITE_START_OFFSET  = 12288,
    parameter int ORIGINAL_ROWS       = 512,
    parameter int ORIGINAL_COLUMNS    = 768,
    parameter int NUM_BITS            = 8,
    parameter int DATA_WIDTH          = 256
) (
    input logic                    clk,
    input logic                    rst,
    writeback_bram_q_k_v_if.slave  bus
);

    localparam int REGION_WORDS = ORIGINAL_ROWS * ORIGINAL_COLUMNS * NUM_BITS / DATA_WIDTH;
    localparam int CNT_W        = $clog2(NUM_WRITES_PER_TILE + 1);

    localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(WRITE_START_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WRITE_START_OFFSET + REGION_WORDS - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(NUM_WRITES_PER_TILE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [CNT_W-1:0]      r_beat;
    logic                  r_wrapped;
    logic                  r_wea;
    logic [ADDR_WIDTH-1:0] r_addra;
    logic [DATA_WIDTH-1:0] r_dina;
    logic                  r_write_done;
    logic                  r_region_done;

    logic w_in_ready;
    logic w_accept;
    logic w_wrap_now;
    logic w_last_beat;

    assign w_in_ready  = (r_state == S_WRITE);
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_wrap_now  = (r_ptr == LAST_ADDR);
    assign w_last_beat = (r_beat == LAST_BEAT);

    assign bus.in_ready    = w_in_ready;
    assign bus.ena         = r_wea;
    assign bus.wea         = r_wea;
    assign bus.addra       = r_addra;
    assign bus.dina        = r_dina;
    assign bus.write_done  = r_write_done;
    assign bus.region_done = r_region_done;
    assign bus.busy        = (r_state != S_IDLE);

    // Tile sequencing, write pointer and registered port-A write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= START_ADDR;
            r_beat        <= '0;
            r_wrapped     <= 1'b0;
            r_wea         <= 1'b0;
            r_addra       <= '0;
            r_dina        <= '0;
            r_write_done  <= 1'b0;
            r_region_done <= 1'b0;
        end else begin
            r_wea         <= 1'b0;
            r_write_done  <= 1'b0;
            r_region_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Rewind is applied in the same edge, so a simultaneous
                    // start begins at the region base.
                    if (bus.reset_addr_counter) begin
                        r_ptr <= START_ADDR;
                    end
                    if (bus.start_write) begin
                        r_state   <= S_WRITE;
                        r_beat    <= '0;
                        r_wrapped <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_wea   <= 1'b1;
                        r_addra <= r_ptr;
                        r_dina  <= bus.in_data;
                        r_beat  <= r_beat + 1'b1;
                        if (w_wrap_now) begin
                            r_ptr     <= START_ADDR;
                            r_wrapped <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state       <= S_DONE;
                            r_write_done  <= 1'b1;
                            r_region_done <= r_wrapped | w_wrap_now;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
